// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, with a registered
// carry between bits. Operands and results move through valid/ready handshakes.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are both
   // high; in_ready/out_valid are pure state decodes, never driven from the inputs.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

   logic fa_s;
   logic fa_c;
   logic last_bit;

   assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q) | (carry_q & a_sh_q[0]);
   assign last_bit = (bit_cnt_q == LAST_BIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last_bit)  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Datapath: operands shift out LSB first, sum bits enter the accumulator from the top.
   always_comb begin
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      bit_cnt_d = bit_cnt_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d    = a;
               b_sh_d    = b;
               carry_d   = cin;
               bit_cnt_d = '0;
            end
         end
         ST_RUN: begin
            acc_d   = {fa_s, acc_q[WIDTH-1:1]};
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = fa_c;
            if (last_bit) begin
               sum_d     = {fa_s, acc_q[WIDTH-1:1]};
               cout_d    = fa_c;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         bit_cnt_q <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         bit_cnt_q <= bit_cnt_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifndef SYNTHESIS
   a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_ready && out_valid));
   a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      bit_cnt_q <= LAST_BIT);
   a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
      state_q != 2'd3);
   a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(sum) && $stable(cout)));
`endif

endmodule
